minus_launcher: RTL and testbench
=================================

MINUS_LAUNCHER -- requirements
Module: minus_launcher

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and difference width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop depth of the chain_fin synchroniser, minimum 2.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum WAIT_FIN cycles before forced capture.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-007 SHALL have ports in_a, in_b (input, WIDTH) and in_bin (input, 1): minuend, subtrahend and borrow-in.
REQ-008 SHALL have ports chain_x, chain_y (output, WIDTH) and chain_cin (output, 1): bundled data to the ripple subtractor chain.
REQ-009 SHALL have port chain_req, output, 1 bit: 4-phase request to stage 0.
REQ-010 SHALL have port chain_fin, input, 1 bit: asynchronous completion from the last stage.
REQ-011 SHALL have ports chain_s (input, WIDTH) and chain_cout (input, 1): chain difference and borrow-out.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-013 SHALL have ports out_diff (output, WIDTH), out_borrow (output, 1) and out_timeout (output, 1): result and timeout flag.

Function
REQ-014 SHALL implement the states IDLE, LAUNCH, WAIT_FIN and DRAIN.
REQ-015 SHALL drive in_ready = (state==IDLE) && !out_valid; acceptance occurs on an edge with in_valid && in_ready.
REQ-016 On acceptance, SHALL register in_a/in_b/in_bin onto chain_x/chain_y/chain_cin and enter LAUNCH; these registers hold until the next acceptance.
REQ-017 In LAUNCH, SHALL set chain_req=1 on the next edge (one cycle of bundled-data setup) and enter WAIT_FIN with the timeout counter cleared.
REQ-018 SHALL pass chain_fin through SYNC_STAGES flops to produce fin_sync; no other logic uses chain_fin.
REQ-019 In WAIT_FIN with fin_sync=1, SHALL capture chain_s/chain_cout into out_diff/out_borrow, set out_valid=1 and out_timeout=0, clear chain_req and enter DRAIN.
REQ-020 In WAIT_FIN with counter==TIMEOUT and fin_sync=0, SHALL capture in the same way but with out_timeout=1.
REQ-021 In DRAIN, SHALL keep chain_req=0 and return to IDLE when fin_sync=0.
REQ-022 SHALL hold out_valid and the result stable until out_valid && out_ready, then clear out_valid; out_timeout is cleared with it.
REQ-023 Minimum latency from the acceptance edge to out_valid=1 SHALL be 2+SYNC_STAGES cycles when chain_fin rises within one cycle of chain_req.
REQ-024 Arithmetic is modulo 2^WIDTH: out_diff = in_a - in_b - in_bin, out_borrow=1 when the true result is negative, as produced by the chain.
REQ-025 If out_valid is still pending when DRAIN ends, SHALL remain in IDLE with in_ready=0 until the result is consumed.
REQ-026 SHALL never assert chain_req while fin_sync=1 (return-to-zero enforced).

Reset
REQ-027 While rst=1 (asynchronous), SHALL force state=IDLE, chain_req=0, chain_x/chain_y/chain_cin=0, out_valid=0, out_diff=0, out_borrow=0, out_timeout=0, in_ready=0, counter=0, and synchroniser flops=0.
REQ-028 Reset asserted mid-operation SHALL drop chain_req immediately and discard the operation, producing no output.

Structure
REQ-029 SHALL place the state enumeration and default WIDTH/SYNC_STAGES/TIMEOUT constants in shared package minus_pkg.
REQ-030 SHALL instantiate the synchroniser as sub-module fin_synchronizer (parameter STAGES, async active-high reset).

Verification
REQ-031 in_a=0x35, in_b=0x12, in_bin=0, chain delay <1 cycle -> out_diff=0x23, out_borrow=0, out_timeout=0, out_valid 4 cycles after acceptance.
REQ-032 in_a=0x10, in_b=0x20, in_bin=1 -> out_diff=0xEF, out_borrow=1.
REQ-033 out_ready held 0 for 10 cycles after out_valid -> result stable, in_ready=0 throughout, new operand accepted on the cycle after the handshake.
REQ-034 TIMEOUT=16, chain_fin stuck at 0 -> out_valid with out_timeout=1 after 16 WAIT_FIN cycles, chain_req=0 afterwards.
REQ-035 rst pulsed during WAIT_FIN -> chain_req=0 within the reset pulse, no out_valid, next operation 0xFF-0x01 returns 0xFE.

Source files
------------

// File: rtl/minus_pkg.sv
// Shared types and default parameters for the subtractor-chain launcher.
package minus_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_FIN = 2'd2,
        DRAIN    = 2'd3
    } state_t;

endpackage

// File: rtl/fin_synchronizer.sv
// Multi-flop synchroniser bringing the asynchronous chain completion into clk.
module fin_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through STAGES flops; only the last one is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/minus_launcher.sv
// Launches one operand set into an asynchronous ripple subtractor chain using a
// 4-phase bundled-data request, then captures the difference with a timeout.
module minus_launcher
    import minus_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic [WIDTH-1:0] chain_x,
    output logic [WIDTH-1:0] chain_y,
    output logic             chain_cin,
    output logic             chain_req,
    input  logic             chain_fin,
    input  logic [WIDTH-1:0] chain_s,
    input  logic             chain_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fin_sync;
    logic             hold_c;

    // chain_fin is only ever observed through this synchroniser
    fin_synchronizer #(
        .STAGES  (SYNC_STAGES)
    ) u_fin_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(chain_fin),
        .sync_out(fin_sync)
    );

    // Result still pending after this edge (no handshake this cycle).
    assign hold_c = out_valid && !out_ready;

    // Launcher FSM with registered chain request, result and in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            chain_x     <= '0;
            chain_y     <= '0;
            chain_cin   <= 1'b0;
            chain_req   <= 1'b0;
            out_valid   <= 1'b0;
            out_diff    <= '0;
            out_borrow  <= 1'b0;
            out_timeout <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid   <= 1'b0;
                out_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        chain_x   <= in_a;
                        chain_y   <= in_b;
                        chain_cin <= in_bin;
                        state     <= LAUNCH;
                        in_ready  <= 1'b0;
                    end else begin
                        in_ready  <= !hold_c;
                    end
                end

                LAUNCH: begin
                    // one cycle of data setup; never raise req until fin has returned to zero
                    in_ready <= 1'b0;
                    if (!fin_sync) begin
                        chain_req <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_FIN;
                    end
                end

                WAIT_FIN: begin
                    in_ready <= 1'b0;
                    if (fin_sync || (cnt == CNT_W'(TIMEOUT))) begin
                        out_diff    <= chain_s;
                        out_borrow  <= chain_cout;
                        out_valid   <= 1'b1;
                        out_timeout <= !fin_sync;
                        chain_req   <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DRAIN: begin
                    chain_req <= 1'b0;
                    if (!fin_sync) begin
                        state    <= IDLE;
                        in_ready <= !hold_c;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    chain_req <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minus_launcher.sv
// Bench for minus_launcher: models the asynchronous subtractor chain and checks
// results against plain integer subtraction of the operands that were sent.
module tb_minus_launcher;

    localparam int unsigned W  = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_bin;
    logic [W-1:0] chain_x, chain_y;
    logic         chain_cin, chain_req;
    logic         chain_fin;
    logic [W-1:0] chain_s;
    logic         chain_cout;
    logic         out_valid, out_ready;
    logic [W-1:0] out_diff;
    logic         out_borrow, out_timeout;

    int checks = 0;
    int errors = 0;
    int chain_dly = 3;
    bit stuck = 1'b0;

    minus_launcher #(
        .WIDTH      (W),
        .SYNC_STAGES(SS),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_bin     (in_bin),
        .chain_x    (chain_x),
        .chain_y    (chain_y),
        .chain_cin  (chain_cin),
        .chain_req  (chain_req),
        .chain_fin  (chain_fin),
        .chain_s    (chain_s),
        .chain_cout (chain_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow),
        .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    // Asynchronous ripple chain: completes chain_dly after req rises, returns to zero after req falls.
    always begin
        @(posedge chain_req);
        if (!stuck) begin
            #(chain_dly);
            if (chain_req) begin
                {chain_cout, chain_s} = {1'b0, chain_x} - {1'b0, chain_y} - 9'(chain_cin);
                chain_fin = 1'b1;
            end
            wait (chain_req == 1'b0);
            #(chain_dly);
            chain_fin = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int dly, input int hold, input bit expect_to);
        int n;
        int lat;
        int t;
        logic [W-1:0] ed;
        logic         eb;
        logic [W-1:0] snap;
        t  = int'(a) - int'(b) - int'(bin);
        ed = W'(t);
        eb = (t < 0);
        chain_dly = dly;
        in_a = a; in_b = b; in_bin = bin; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("chain_x", 32'(chain_x), 32'(a));
        chk("chain_y", 32'(chain_y), 32'(b));
        chk("chain_cin", 32'(chain_cin), 32'(bin));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (lat == 1) chk("chain_req_set", 32'(chain_req), 32'd1);
        end while (out_valid !== 1'b1 && lat < 60);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_timeout", 32'(out_timeout), 32'(expect_to));
        chk("chain_req_clr", 32'(chain_req), 32'd0);
        if (expect_to) begin
            chk("timeout_latency", 32'(lat), 32'(2 + TO));
        end else begin
            chk("out_diff", 32'(out_diff), 32'(ed));
            chk("out_borrow", 32'(out_borrow), 32'(eb));
            if (dly < 10) chk("latency", 32'(lat), 32'(2 + SS));
        end
        snap = out_diff;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_diff", 32'(out_diff), 32'(expect_to ? snap : ed));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (expect_to) chk("hold_chain_req", 32'(chain_req), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_cleared", 32'(out_valid), 32'd0);
        chk("timeout_cleared", 32'(out_timeout), 32'd0);
        if (hold >= 10) chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        int           seen;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_bin = 1'b0;
        out_ready = 1'b0;
        chain_fin = 1'b0; chain_s = '0; chain_cout = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_chain_req", 32'(chain_req), 32'd0);
        chk("rst_chain_x", 32'(chain_x), 32'd0);
        chk("rst_out_diff", 32'(out_diff), 32'd0);
        chk("rst_out_timeout", 32'(out_timeout), 32'd0);
        #21 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed: fast chain, basic difference with exact latency
        do_op(8'h35, 8'h12, 1'b0, 4, 0, 1'b0);
        // Directed: negative result with borrow-in
        do_op(8'h10, 8'h20, 1'b1, 6, 0, 1'b0);
        // Directed: consumer stalls for 10 cycles
        do_op(8'hA5, 8'h3C, 1'b1, 2, 10, 1'b0);
        // Boundaries
        do_op(8'h00, 8'h00, 1'b1, 7, 1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 25, 2, 1'b0);

        // Randomized operands and chain delays
        for (int k = 0; k < 20; k++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            do_op(ra, rb, rbin, int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Chain never completes: forced capture with timeout flag
        stuck = 1'b1;
        do_op(8'h55, 8'h11, 1'b0, 3, 10, 1'b1);

        // Reset in the middle of WAIT_FIN discards the operation
        in_a = 8'h77; in_b = 8'h01; in_bin = 1'b0; in_valid = 1'b1;
        seen = 0;
        while (in_ready !== 1'b1 && seen < 50) begin
            @(posedge clk); #1; seen++;
        end
        chk("rst_test_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_test_req_high", 32'(chain_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_chain_req", 32'(chain_req), 32'd0);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        #10 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || chain_req !== 1'b0) seen++;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);
        stuck = 1'b0;
        do_op(8'hFF, 8'h01, 1'b0, 5, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so a wedged DUT still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
